morse_tx: RTL

MORSE_TX -- requirements
Module: morse_tx

---
 rtl/morse_tx_if.sv | 20 ++
 rtl/morse_tx.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/morse_tx_if.sv
// Character request / Morse keying bundle for morse_tx.
// The requester drives ascii_char and start; the transmitter drives the rest.
interface morse_tx_if;
  logic [7:0] ascii_char;
  logic       start;
  logic       key_out;
  logic       busy;
  logic       letter_done;
  logic       invalid;

  modport master (
    output ascii_char, start,
    input  key_out, busy, letter_done, invalid
  );

  modport slave (
    input  ascii_char, start,
    output key_out, busy, letter_done, invalid
  );
endinterface

// File: rtl/morse_tx.sv
// Single-character ITU Morse transmitter: letters, digits and word space,
// timed in units of UNIT_CYCLES clocks, with a 3-unit trailing letter gap.
module morse_tx #(
  parameter int unsigned UNIT_CYCLES = 10000000
) (
  input  logic     clock,
  input  logic     reset,
  morse_tx_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] MARK  = 2'd1;
  localparam logic [1:0] SPACE = 2'd2;
  localparam logic [1:0] LGAP  = 2'd3;

  localparam logic [31:0] UNIT_LAST = 32'(UNIT_CYCLES - 1);

  logic [1:0]  state;
  logic [31:0] unit_cnt;
  logic [2:0]  phase_cnt;
  logic [4:0]  elem_bits;
  logic [2:0]  elem_left;
  logic        key_q;
  logic        busy_q;
  logic        done_q;
  logic        invalid_q;

  logic [7:0]  up_char;
  logic        sym_ok;
  logic [2:0]  sym_len;
  logic [4:0]  sym_bits;
  logic        tick;

  assign tick            = (unit_cnt == UNIT_LAST);
  assign bus.key_out     = key_q;
  assign bus.busy        = busy_q;
  assign bus.letter_done = done_q;
  assign bus.invalid     = invalid_q;

  // Symbol table: length and elements left-aligned, bit 4 is sent first (1 = dash).
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    sym_ok   = 1'b1;
    sym_len  = 3'd0;
    sym_bits = 5'b00000;
    up_char  = bus.ascii_char;
    if (up_char >= "a" && up_char <= "z") up_char = up_char - 8'h20;
    case (up_char)
      "A": {sym_len, sym_bits} = {3'd2, 5'b01000};
      "B": {sym_len, sym_bits} = {3'd4, 5'b10000};
      "C": {sym_len, sym_bits} = {3'd4, 5'b10100};
      "D": {sym_len, sym_bits} = {3'd3, 5'b10000};
      "E": {sym_len, sym_bits} = {3'd1, 5'b00000};
      "F": {sym_len, sym_bits} = {3'd4, 5'b00100};
      "G": {sym_len, sym_bits} = {3'd3, 5'b11000};
      "H": {sym_len, sym_bits} = {3'd4, 5'b00000};
      "I": {sym_len, sym_bits} = {3'd2, 5'b00000};
      "J": {sym_len, sym_bits} = {3'd4, 5'b01110};
      "K": {sym_len, sym_bits} = {3'd3, 5'b10100};
      "L": {sym_len, sym_bits} = {3'd4, 5'b01000};
      "M": {sym_len, sym_bits} = {3'd2, 5'b11000};
      "N": {sym_len, sym_bits} = {3'd2, 5'b10000};
      "O": {sym_len, sym_bits} = {3'd3, 5'b11100};
      "P": {sym_len, sym_bits} = {3'd4, 5'b01100};
      "Q": {sym_len, sym_bits} = {3'd4, 5'b11010};
      "R": {sym_len, sym_bits} = {3'd3, 5'b01000};
      "S": {sym_len, sym_bits} = {3'd3, 5'b00000};
      "T": {sym_len, sym_bits} = {3'd1, 5'b10000};
      "U": {sym_len, sym_bits} = {3'd3, 5'b00100};
      "V": {sym_len, sym_bits} = {3'd4, 5'b00010};
      "W": {sym_len, sym_bits} = {3'd3, 5'b01100};
      "X": {sym_len, sym_bits} = {3'd4, 5'b10010};
      "Y": {sym_len, sym_bits} = {3'd4, 5'b10110};
      "Z": {sym_len, sym_bits} = {3'd4, 5'b11000};
      "0": {sym_len, sym_bits} = {3'd5, 5'b11111};
      "1": {sym_len, sym_bits} = {3'd5, 5'b01111};
      "2": {sym_len, sym_bits} = {3'd5, 5'b00111};
      "3": {sym_len, sym_bits} = {3'd5, 5'b00011};
      "4": {sym_len, sym_bits} = {3'd5, 5'b00001};
      "5": {sym_len, sym_bits} = {3'd5, 5'b00000};
      "6": {sym_len, sym_bits} = {3'd5, 5'b10000};
      "7": {sym_len, sym_bits} = {3'd5, 5'b11000};
      "8": {sym_len, sym_bits} = {3'd5, 5'b11100};
      "9": {sym_len, sym_bits} = {3'd5, 5'b11110};
      default: sym_ok = 1'b0;
    endcase
  end

  // Outputs are registered alongside the state so key_out/busy follow it with no extra delay.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      unit_cnt  <= 32'd0;
      phase_cnt <= 3'd0;
      elem_bits <= 5'b00000;
      elem_left <= 3'd0;
      key_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees pre-edge state.
      done_q    <= 1'b0;
      invalid_q <= 1'b0;
      if (state == IDLE) begin
        if (bus.start) begin
          unit_cnt <= 32'd0;
          if (sym_ok) begin
            state     <= MARK;
            key_q     <= 1'b1;
            busy_q    <= 1'b1;
            phase_cnt <= sym_bits[4] ? 3'd3 : 3'd1;
            elem_bits <= {sym_bits[3:0], 1'b0};
            elem_left <= sym_len - 3'd1;
          end else if (bus.ascii_char == 8'h20) begin
            state     <= LGAP;
            busy_q    <= 1'b1;
            phase_cnt <= 3'd7;
          end else begin
            invalid_q <= 1'b1;
          end
        end
      end else if (!tick) begin
        unit_cnt <= unit_cnt + 32'd1;
      end else begin
        unit_cnt <= 32'd0;
        if (phase_cnt != 3'd1) begin
          phase_cnt <= phase_cnt - 3'd1;
        end else begin
          case (state)
            MARK: begin
              key_q <= 1'b0;
              if (elem_left != 3'd0) begin
                state     <= SPACE;
                phase_cnt <= 3'd1;
              end else begin
                state     <= LGAP;
                phase_cnt <= 3'd3;
              end
            end
            SPACE: begin
              state     <= MARK;
              key_q     <= 1'b1;
              phase_cnt <= elem_bits[4] ? 3'd3 : 3'd1;
              elem_bits <= {elem_bits[3:0], 1'b0};
              elem_left <= elem_left - 3'd1;
            end
            default: begin
              state  <= IDLE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          endcase
        end
      end
    end
  end

endmodule
